// File: rtl/act_lut_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_lut_loader_pkg
// Description : Shared definitions for the activation-LUT loader and the
//               activation block. It holds the loader FSM state encoding,
//               the default LUT geometry and the bit positions of the
//               q_encode fields inside the quantisation-encode word.
// Revision    : 1.0 - initial release
// ============================================================================
package act_lut_loader_pkg;

    // Default LUT geometry
    localparam int ACT_LUT_WIDTH  = 24;
    localparam int ACT_ADDR_WIDTH = 5;
    localparam int ACT_LUT_DEPTH  = 16;

    // q_encode field positions (MSB of each 4-bit field) in the encode word
    localparam int QENC_FIELD_W  = 4;
    localparam int QENC_C_MSB    = 23;
    localparam int QENC_W_MSB    = 19;
    localparam int QENC_O_MSB    = 15;

    // Loader FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_COE  = 2'd1,
        ST_LOAD_QENC = 2'd2,
        ST_DONE      = 2'd3
    } loader_state_t;

endpackage : act_lut_loader_pkg
`default_nettype wire

// File: rtl/act_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : act_lut_loader
// Description : Writer side of the activation-LUT BRAM-controller port.
//               Accepts a valid/ready stream of config words and writes
//               LUT_DEPTH coefficients (addresses 0..LUT_DEPTH-1) followed by
//               one q_encode word (address LUT_DEPTH). Keeps a shadow copy of
//               the q_encode fields and reports load status.
// Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//               i_start, i_abort      - begin / cancel a load (pulses)
//               i_cfg_dat/vld, o_cfg_rdy - config word stream
//               o_lut_bramctl_*       - registered BRAM write port
//               o_busy, o_done, o_err, o_lut_valid - status
//               o_act_{c,w,o}_q_encode - shadow q_encode fields
// Revision    : 1.0 - initial release
// ============================================================================
module act_lut_loader
    import act_lut_loader_pkg::*;
#(
    parameter int LUT_WIDTH  = ACT_LUT_WIDTH,
    parameter int ADDR_WIDTH = ACT_ADDR_WIDTH,
    parameter int LUT_DEPTH  = ACT_LUT_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LUT_WIDTH-1:0]  i_cfg_dat,
    input  logic                  i_cfg_vld,
    output logic                  o_cfg_rdy,
    output logic [LUT_WIDTH-1:0]  o_lut_bramctl_wdata,
    output logic [ADDR_WIDTH-1:0] o_lut_bramctl_addr,
    output logic                  o_lut_bramctl_we,
    output logic                  o_lut_bramctl_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_lut_valid,
    output logic [3:0]            o_act_c_q_encode,
    output logic [3:0]            o_act_w_q_encode,
    output logic [3:0]            o_act_o_q_encode
);

    localparam logic [ADDR_WIDTH-1:0] c_last_coe = ADDR_WIDTH'(LUT_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_qenc_adr = ADDR_WIDTH'(LUT_DEPTH);

    loader_state_t           r_state;
    loader_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [LUT_WIDTH-1:0]    r_wdata;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic                    r_err;
    logic                    r_lut_valid;
    logic [3:0]              r_q_c;
    logic [3:0]              r_q_w;
    logic [3:0]              r_q_o;

    logic                    w_rdy;
    logic                    w_busy;
    logic                    w_acc;
    logic                    w_begin;
    logic                    w_done;

    // Ready is a pure state decode so it never combinationally follows vld.
    // An abort suppresses acceptance of whatever word is on the bus.
    always_comb begin
        w_rdy   = (r_state == ST_LOAD_COE) || (r_state == ST_LOAD_QENC);
        w_busy  = (r_state != ST_IDLE);
        w_acc   = w_rdy && i_cfg_vld && !i_abort;
        w_begin = (r_state == ST_IDLE) && i_start && !i_abort;
        // An abort arriving in DONE cancels the completion report.
        w_done  = (r_state == ST_DONE) && !i_abort;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_begin) begin
                    w_state_nxt = ST_LOAD_COE;
                end
            end
            ST_LOAD_COE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_acc && (r_cnt == c_last_coe)) begin
                    w_state_nxt = ST_LOAD_QENC;
                end
            end
            ST_LOAD_QENC: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_acc) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter, write port and status registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_lut_valid <= 1'b0;
            r_q_c       <= '0;
            r_q_w       <= '0;
            r_q_o       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_acc;

            if (w_acc) begin
                r_wdata <= i_cfg_dat;
                r_addr  <= (r_state == ST_LOAD_QENC) ? c_qenc_adr : r_cnt;
            end

            if (w_begin) begin
                r_cnt <= '0;
            end else if (w_acc && (r_state == ST_LOAD_COE)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Error: abort of a live load, or a start that arrives while busy.
            // A fresh load clears it.
            if (w_begin) begin
                r_err <= 1'b0;
            end else if (w_busy && (i_abort || i_start)) begin
                r_err <= 1'b1;
            end

            if (w_begin) begin
                r_lut_valid <= 1'b0;
            end else if (w_done) begin
                r_lut_valid <= 1'b1;
            end

            // Shadow fields update together with the q_encode BRAM write.
            if (w_acc && (r_state == ST_LOAD_QENC)) begin
                r_q_c <= i_cfg_dat[QENC_C_MSB -: QENC_FIELD_W];
                r_q_w <= i_cfg_dat[QENC_W_MSB -: QENC_FIELD_W];
                r_q_o <= i_cfg_dat[QENC_O_MSB -: QENC_FIELD_W];
            end
        end
    end

    assign o_cfg_rdy           = w_rdy;
    assign o_lut_bramctl_wdata = r_wdata;
    assign o_lut_bramctl_addr  = r_addr;
    assign o_lut_bramctl_we    = r_we;
    assign o_lut_bramctl_en    = r_we;
    assign o_busy              = w_busy;
    assign o_done              = w_done;
    assign o_err               = r_err;
    // Valid rises in the DONE cycle itself, alongside the final write.
    assign o_lut_valid         = r_lut_valid || w_done;
    assign o_act_c_q_encode    = r_q_c;
    assign o_act_w_q_encode    = r_q_w;
    assign o_act_o_q_encode    = r_q_o;

endmodule : act_lut_loader
`default_nettype wire

// File: tb/tb_act_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_lut_loader
// Description : Self-checking bench for act_lut_loader. A driver issues
//               directed loads and queues the expected BRAM writes; a monitor
//               on the falling edge pops and compares each presented write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_lut_loader;

    localparam int c_w = 24;
    localparam int c_a = 5;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_abort = 1'b0;
    logic [c_w-1:0] i_cfg_dat = '0;
    logic           i_cfg_vld = 1'b0;
    logic           o_cfg_rdy;
    logic [c_w-1:0] o_lut_bramctl_wdata;
    logic [c_a-1:0] o_lut_bramctl_addr;
    logic           o_lut_bramctl_we;
    logic           o_lut_bramctl_en;
    logic           o_busy;
    logic           o_done;
    logic           o_err;
    logic           o_lut_valid;
    logic [3:0]     o_act_c_q_encode;
    logic [3:0]     o_act_w_q_encode;
    logic [3:0]     o_act_o_q_encode;

    act_lut_loader #(
        .LUT_WIDTH (c_w),
        .ADDR_WIDTH(c_a),
        .LUT_DEPTH (16)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_abort            (i_abort),
        .i_cfg_dat          (i_cfg_dat),
        .i_cfg_vld          (i_cfg_vld),
        .o_cfg_rdy          (o_cfg_rdy),
        .o_lut_bramctl_wdata(o_lut_bramctl_wdata),
        .o_lut_bramctl_addr (o_lut_bramctl_addr),
        .o_lut_bramctl_we   (o_lut_bramctl_we),
        .o_lut_bramctl_en   (o_lut_bramctl_en),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err),
        .o_lut_valid        (o_lut_valid),
        .o_act_c_q_encode   (o_act_c_q_encode),
        .o_act_w_q_encode   (o_act_w_q_encode),
        .o_act_o_q_encode   (o_act_o_q_encode)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    // Expected writes: {addr, data}
    logic [c_a+c_w-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compare every presented write against the scoreboard
    always @(negedge i_clk) begin
        logic [c_a+c_w-1:0] e;
        if (o_lut_bramctl_we || o_lut_bramctl_en) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         o_lut_bramctl_addr, o_lut_bramctl_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({o_lut_bramctl_addr, o_lut_bramctl_wdata} !== e ||
                    o_lut_bramctl_en !== o_lut_bramctl_we) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data 0x%0h we %b en %b, expected addr %0d data 0x%0h we=en=1",
                             o_lut_bramctl_addr, o_lut_bramctl_wdata, o_lut_bramctl_we,
                             o_lut_bramctl_en, e[c_a+c_w-1:c_w], e[c_w-1:0]);
                end
            end
        end
        if (o_cfg_rdy && !o_busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdy_in_idle: got rdy 1 busy 0, expected rdy 0");
        end
        if (o_done) n_done++;
    end

    // One load: start, then 16 coefficients 0x000100+i and the q_encode word.
    // abort_at / rst_at cut the load short at that word index; start_at
    // re-pulses i_start alongside that word. Returns cycles from start to DONE.
    task automatic run_load(input logic [c_w-1:0] q, input bit gap, input int abort_at,
                            input int start_at, input int rst_at, output int dcyc);
        logic [c_w-1:0] word;
        dcyc = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            word = (i < 16) ? (24'h000100 + 24'(i)) : q;
            if (i == abort_at) begin
                i_cfg_vld = 1'b1;
                i_cfg_dat = word;
                i_abort   = 1'b1;
                tick();
                i_abort   = 1'b0;
                i_cfg_vld = 1'b0;
                return;
            end
            if (i == rst_at) begin
                i_cfg_vld = 1'b0;
                i_rst     = 1'b1;
                tick();
                i_rst     = 1'b0;
                return;
            end
            i_cfg_vld = 1'b1;
            i_cfg_dat = word;
            if (i == start_at) i_start = 1'b1;
            chk("cfg_rdy", 32'(o_cfg_rdy), 32'd1);
            exp_q.push_back({5'(i), word});
            tick();
            dcyc++;
            i_start = 1'b0;
            if (gap && i < 16) begin
                i_cfg_vld = 1'b0;
                i_cfg_dat = 24'hDEAD00;
                tick();
                dcyc++;
            end
        end
        i_cfg_vld = 1'b0;
    endtask

    task automatic chk_shadow(input string name, input logic [11:0] req);
        chk(name, 32'({o_act_c_q_encode, o_act_w_q_encode, o_act_o_q_encode}), 32'(req));
    endtask

    initial begin
        int d0;
        int d1;
        int nd;

        tick();
        tick();
        i_rst = 1'b0;
        chk("reset_state", 32'({o_cfg_rdy, o_busy, o_done, o_err, o_lut_valid, o_lut_bramctl_we}), 32'd0);
        chk_shadow("reset_shadow", 12'h000);

        // Zero-gap load
        run_load(24'hA53000, 1'b0, -1, -1, -1, d0);
        chk("zg_done", 32'(o_done), 32'd1);
        chk("zg_valid", 32'(o_lut_valid), 32'd1);
        chk("zg_latency", 32'(d0), 32'd17);
        chk("zg_err", 32'(o_err), 32'd0);
        chk_shadow("zg_shadow", 12'hA53);
        tick();
        chk("zg_busy_fall", 32'({o_busy, o_done, o_lut_valid}), 32'b001);

        // Gapped load
        run_load(24'hA53000, 1'b1, -1, -1, -1, d1);
        chk("gap_done", 32'(o_done), 32'd1);
        chk("gap_latency", 32'(d1), 32'(d0 + 16));
        tick();

        // Abort after 7 words
        nd = n_done;
        run_load(24'h777000, 1'b0, 7, -1, -1, d1);
        chk("abort_status", 32'({o_cfg_rdy, o_busy, o_done, o_err, o_lut_valid}), 32'b00010);
        chk_shadow("abort_shadow", 12'hA53);
        tick();
        tick();
        chk("abort_no_done", 32'(n_done), 32'(nd));
        chk("abort_writes", 32'(exp_q.size()), 32'd0);

        // Start pulsed during word 3
        run_load(24'hA53000, 1'b0, -1, 3, -1, d1);
        chk("restart_done", 32'(o_done), 32'd1);
        chk("restart_err", 32'(o_err), 32'd1);
        tick();

        // Reset after 10 words
        run_load(24'hA53000, 1'b0, -1, -1, 10, d1);
        chk("rst_outputs", 32'({o_cfg_rdy, o_busy, o_done, o_err, o_lut_valid,
                                o_lut_bramctl_we, o_lut_bramctl_en}), 32'd0);
        chk("rst_bus", 32'({o_lut_bramctl_addr, o_lut_bramctl_wdata}), 32'd0);
        chk_shadow("rst_shadow", 12'h000);
        run_load(24'hA53000, 1'b0, -1, -1, -1, d1);
        chk("post_rst_done", 32'({o_done, o_err}), 32'b10);
        tick();

        // Back-to-back loads
        run_load(24'hA53000, 1'b0, -1, -1, -1, d1);
        chk("b2b_done1", 32'(o_done), 32'd1);
        tick();
        run_load(24'h123000, 1'b0, -1, -1, -1, d1);
        chk("b2b_done2", 32'(o_done), 32'd1);
        chk_shadow("b2b_shadow", 12'h123);
        tick();
        tick();
        chk("total_done", 32'(n_done), 32'd6);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_act_lut_loader
`default_nettype wire
